// File: rtl/pc_ctrl_pkg.sv
// Shared widths and FSM state encoding for the program-counter controller.
package pc_ctrl_pkg;
    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/pc_ctrl_next_calc.sv
// Combinational next-PC selection: halt hold, absolute jump, taken relative branch, sequential.
module pc_next_calc #(
    parameter int PC_W  = pc_ctrl_pkg::PC_W,
    parameter int OFF_W = pc_ctrl_pkg::OFF_W
) (
    input  logic [PC_W-1:0]  pc_i,
    input  logic [OFF_W-1:0] target_i,
    input  logic             halt_i,
    input  logic             jump_abs_i,
    input  logic             branch_rel_i,
    input  logic             taken_i,
    output logic [PC_W-1:0]  pc_next_o
);
    logic [PC_W-1:0] tgt_zext;
    logic [PC_W-1:0] tgt_sext;

    assign tgt_zext = {{(PC_W-OFF_W){1'b0}}, target_i};
    assign tgt_sext = {{(PC_W-OFF_W){target_i[OFF_W-1]}}, target_i};

    // Additions wrap naturally at PC_W bits, giving modulo-2^PC_W addressing.
    always_comb begin
        pc_next_o = pc_i + PC_W'(1);
        if (halt_i)
            pc_next_o = pc_i;
        else if (jump_abs_i)
            pc_next_o = tgt_zext;
        else if (branch_rel_i && taken_i)
            pc_next_o = pc_i + tgt_sext;
    end
endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: IDLE/RUN/DONE sequencing, PC register and saturating run-cycle counter.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W  = pc_ctrl_pkg::PC_W,
    parameter int OFF_W = pc_ctrl_pkg::OFF_W,
    parameter int CNT_W = pc_ctrl_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic             jump_abs_i,
    input  logic             branch_rel_i,
    input  logic             taken_i,
    input  logic [OFF_W-1:0] target_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             fetch_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_count_o
);
    state_e           state_q;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_q, done_q;

    pc_next_calc #(.PC_W(PC_W), .OFF_W(OFF_W)) u_next (
        .pc_i         (pc_q),
        .target_i     (target_i),
        .halt_i       (halt_i),
        .jump_abs_i   (jump_abs_i),
        .branch_rel_i (branch_rel_i),
        .taken_i      (taken_i),
        .pc_next_o    (pc_d)
    );

    assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            fetch_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                        fetch_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // The halt edge itself still counts as a run cycle.
                    pc_q  <= pc_d;
                    cnt_q <= cnt_d;
                    if (halt_i) begin
                        state_q <= DONE;
                        fetch_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    fetch_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign fetch_o       = fetch_q;
    assign done_o        = done_q;
    assign cycle_count_o = cnt_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Scenario bench for pc_ctrl: expected output tuples are queued at drive time and checked after each edge.
module tb_pc_ctrl;
    import pc_ctrl_pkg::*;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             fetch;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0, halt = 1'b0, jmp = 1'b0, br = 1'b0, tkn = 1'b0;
    logic [OFF_W-1:0] tgt = '0;
    logic [PC_W-1:0]  pc;
    logic             fetch, done;
    logic [CNT_W-1:0] cnt;

    obs_t exp_q[$];
    obs_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .halt_i        (halt),
        .jump_abs_i    (jmp),
        .branch_rel_i  (br),
        .taken_i       (tkn),
        .target_i      (tgt),
        .pc_o          (pc),
        .fetch_o       (fetch),
        .done_o        (done),
        .cycle_count_o (cnt)
    );

    function automatic obs_t mk(input int p, input logic f, input logic d, input int c);
        obs_t o;
        o.pc    = PC_W'(p);
        o.fetch = f;
        o.done  = d;
        o.cnt   = CNT_W'(c);
        return o;
    endfunction

    function automatic obs_t obs();
        return {pc, fetch, done, cnt};
    endfunction

    // Drive one cycle of inputs on the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic s, input logic h, input logic j, input logic b,
                       input logic t, input logic [OFF_W-1:0] tg);
        @(negedge clk);
        start = s; halt = h; jmp = j; br = b; tkn = t; tgt = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        exp_q.push_back(mk(0, 0, 0, 0));
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_async got %h want %h", obs(), e); end
        exp_q.push_back(mk(0, 0, 0, 0));
        cyc(1, 0, 1, 0, 0, 8'd7);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_start_ignored got %h want %h", obs(), e); end
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));
        cyc(0, 1, 1, 1, 1, 8'd7);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL idle_hold got %h want %h", obs(), e); end
    endtask

    task automatic test_sequential;
        exp_q.push_back(mk(0, 1, 0, 0));
        cyc(1, 0, 0, 0, 0, 8'd0);
        for (int i = 1; i <= 6; i++) begin
            e = exp_q.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL seq step %0d got %h want %h", i - 1, obs(), e); end
            exp_q.push_back(mk(i, 1, 0, i));
            cyc(0, 0, 0, 0, 0, 8'd0);
        end
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL seq step 6 got %h want %h", obs(), e); end
    endtask

    task automatic test_branch;
        exp_q.push_back(mk(5, 1, 0, 7));
        cyc(0, 0, 0, 1, 1, 8'hFF);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL branch_back got %h want %h", obs(), e); end
        exp_q.push_back(mk(6, 1, 0, 8));
        cyc(0, 0, 0, 0, 0, 8'd0);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL branch_reseq got %h want %h", obs(), e); end
        exp_q.push_back(mk(7, 1, 0, 9));
        cyc(0, 0, 0, 1, 0, 8'hFF);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL branch_not_taken got %h want %h", obs(), e); end
    endtask

    task automatic test_jump;
        obs_t exp_list[$];
        exp_list = '{mk(3, 1, 0, 10), mk(30, 1, 0, 11), mk(0, 1, 0, 12), mk(1023, 1, 0, 13),
                     mk(0, 1, 0, 14), mk(5, 1, 0, 15), mk(9, 1, 0, 16)};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(exp_list[i]);
            case (i)
                0: cyc(0, 0, 1, 0, 0, 8'd3);
                1: cyc(0, 0, 1, 0, 0, 8'd30);
                2: cyc(0, 0, 1, 1, 1, 8'd0);    // jump outranks branch
                3: cyc(0, 0, 0, 1, 1, 8'hFF);   // 0 - 1 wraps to 1023
                4: cyc(0, 0, 0, 0, 0, 8'd0);    // 1023 + 1 wraps to 0
                5: cyc(0, 0, 0, 1, 1, 8'd5);
                default: cyc(0, 0, 1, 0, 0, 8'd9);
            endcase
            e = exp_q.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL jump step %0d got %h want %h", i, obs(), e); end
        end
    endtask

    task automatic test_halt;
        exp_q.push_back(mk(9, 0, 1, 17));
        cyc(0, 1, 1, 0, 0, 8'd40);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL halt_priority got %h want %h", obs(), e); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(9, 0, 1, 17));
            cyc(0, i == 2, i == 0, i == 1, 1'b1, 8'd50);
            e = exp_q.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL done_frozen %0d got %h want %h", i, obs(), e); end
        end
        exp_q.push_back(mk(0, 1, 0, 0));
        cyc(1, 0, 0, 0, 0, 8'd0);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL relaunch got %h want %h", obs(), e); end
        exp_q.push_back(mk(1, 1, 0, 1));
        cyc(1, 0, 0, 0, 0, 8'd0);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL start_in_run got %h want %h", obs(), e); end
    endtask

    task automatic test_spin_saturate;
        int c;
        for (int i = 1; i <= 70000; i++) begin
            c = (1 + i > 65535) ? 65535 : 1 + i;
            if (i % 5000 == 0 || (i >= 65532 && i <= 65536) || i == 70000) begin
                exp_q.push_back(mk(1, 1, 0, c));
                cyc(0, 0, 0, 1, 1, 8'd0);
                e = exp_q.pop_front(); n_chk++;
                if (obs() !== e) begin n_fail++; $display("FAIL spin i=%0d got %h want %h", i, obs(), e); end
            end else begin
                cyc(0, 0, 0, 1, 1, 8'd0);
            end
        end
        exp_q.push_back(mk(1, 0, 1, 65535));
        cyc(0, 1, 0, 0, 0, 8'd0);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL halt_saturated got %h want %h", obs(), e); end
    endtask

    task automatic test_async_reset;
        exp_q.push_back(mk(0, 1, 0, 0));
        cyc(1, 0, 0, 0, 0, 8'd0);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL rerun_launch got %h want %h", obs(), e); end
        for (int i = 1; i <= 12; i++) cyc(0, 0, 0, 0, 0, 8'd0);
        exp_q.push_back(mk(12, 1, 0, 12));
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL pre_reset got %h want %h", obs(), e); end
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0));
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL midcycle_reset got %h want %h", obs(), e); end
        exp_q.push_back(mk(0, 0, 0, 0));
        cyc(1, 0, 0, 0, 0, 8'd0);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL start_under_reset got %h want %h", obs(), e); end
        rst = 1'b0;
        exp_q.push_back(mk(0, 1, 0, 0));
        cyc(1, 0, 0, 0, 0, 8'd0);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL post_reset_launch got %h want %h", obs(), e); end
        exp_q.push_back(mk(1, 1, 0, 1));
        cyc(0, 0, 0, 0, 0, 8'd0);
        e = exp_q.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL post_reset_step got %h want %h", obs(), e); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_halt();
        test_spin_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter controller for the single-cycle core. Holds the instruction-memory address and sequences program start and halt. Applies absolute jumps and conditional relative branches, whose 8-bit operand comes from the immediate/target lookup table (the downstream consumer of that table's output). It also provides the fetch-valid strobe, the done flag and a run-cycle counter to the testbench.

## Interface
- PC_W, 10, program-counter width (1024-entry instruction memory)
- OFF_W, 8, width of the lookup-table target/offset operand
- CNT_W, 16, width of the run-cycle counter
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  level sampled each edge; launches program from address 0 when not running
- Halt  input  1  decoded halt instruction at current PC
- JumpAbs  input  1  decoded absolute jump at current PC
- BranchRel  input  1  decoded relative branch at current PC
- Taken  input  1  branch condition result (qualifies BranchRel only)
- Target  input  OFF_W  lookup-table output; unsigned absolute address for JumpAbs, two's-complement offset for BranchRel
- PC  output  PC_W  current instruction address
- Fetch  output  1  high while the instruction at PC is being executed
- Done  output  1  high after Halt until next launch
- CycleCount  output  CNT_W  number of RUN cycles since last launch

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, PC=0, Fetch=0, Done=0, CycleCount=0, regardless of clock.
- IDLE: Start=1 -> RUN, PC=0, CycleCount=0. Otherwise hold.
- RUN: every edge computes next PC with fixed priority:
  - Halt -> DONE; PC holds.
  - else JumpAbs -> PC = zero-extended Target.
  - else BranchRel & Taken -> PC = PC + sign-extended Target, modulo 2^PC_W.
  - else PC = PC + 1, modulo 2^PC_W. This includes BranchRel with Taken=0.
- Decode inputs (Halt, JumpAbs, BranchRel, Taken, Target) are ignored outside RUN.
- Start is ignored in RUN and does not restart the program.
- DONE: Done=1, PC frozen. Start=1 -> RUN, PC=0, CycleCount=0, Done=0.
- CycleCount increments by 1 on every edge taken in RUN, including the Halt edge. It saturates at 2^CNT_W-1 and never wraps.
- Branch with Target=0 and Taken=1 holds PC (spin loop). This is legal and must not stall the FSM.
- Target=8'hFF (-1) branches to PC-1. From PC=0 this wraps to 2^PC_W-1.
- Multiple decode strobes asserted together resolve by the priority above. No error flag is raised.

## Timing
- All outputs are registered or decoded only from registered state. No combinational path from any input to any output.
- Fetch = (state==RUN). Done = (state==DONE).
- Launch latency: Start high at edge N -> PC=0 and Fetch=1 from edge N until next update. The first instruction executes in cycle N..N+1.
- Each RUN instruction takes exactly one cycle. The redirect is visible at PC one edge after the decode strobe is sampled.
- Halt sampled at edge M while PC=k -> after M: Fetch=0, Done=1, PC=k.
- Async reset mid-RUN returns all outputs to reset values immediately. The first launch after reset needs a Start edge with Reset low.

## Structure
- Shared package: the state enum typedef (IDLE, RUN, DONE) and the default width constants PC_W, OFF_W and CNT_W, so decode and testbench agree.
- One natural sub-module: pc_next_calc. It is purely combinational: it takes PC, Target and the strobes and returns the next PC, including the sign/zero extension and priority mux.
- The top level holds the FSM, the PC register and the saturating counter.

## Test plan
- Reset then Start=1 for one cycle; no branches for 5 cycles -> PC sequence 0,1,2,3,4,5. Fetch=1, CycleCount=5, Done=0.
- At PC=6, BranchRel=1, Taken=1, Target=8'hFF -> PC=5 next cycle. Repeat with Taken=0 -> PC=7.
- At PC=3, JumpAbs=1, Target=8'd30 -> PC=30. At PC=0, BranchRel=1, Taken=1, Target=8'hFF -> PC=1023.
- At PC=9, Halt=1 with JumpAbs=1 simultaneously -> DONE, PC=9, Done=1, Fetch=0. Subsequent strobes leave PC=9. Start -> PC=0, Done=0, CycleCount=0.
- Spin branch (Target=0, Taken=1) held for 70000 cycles -> PC constant, CycleCount saturates at 65535.
- Assert Reset asynchronously mid-cycle at PC=12 in RUN -> immediately PC=0, Fetch=0, Done=0, CycleCount=0, state IDLE. Start ignored while Reset high.
